// File: rtl/sipo_deserializer_pkg.sv
// Shared types and constants for the SIPO deserializer.
// Optional parity bit per frame is enabled by defining SIPO_PARITY_EN.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 3;

`ifdef SIPO_PARITY_EN
  localparam int unsigned SIPO_PAR_BITS = 1;
`else
  localparam int unsigned SIPO_PAR_BITS = 0;
`endif

  // Serial bits per frame: data bits plus the optional trailing parity bit.
  function automatic int unsigned sipo_frame_len(input int unsigned width);
    return width + SIPO_PAR_BITS;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial link input plus valid/ready parallel output of the SIPO deserializer.
// master: upstream link and downstream consumer side; slave: the deserializer.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 3
);
  logic             si;
  logic             sen;
  logic             sof;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             overrun;
  logic             perr;

  modport master (
    output si, sen, sof, q_ready,
    input  q, q_valid, overrun, perr
  );

  modport slave (
    input  si, sen, sof, q_ready,
    output q, q_valid, overrun, perr
  );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for one serial frame, MSB first.
// 'done' flags the edge that captures the final bit; 'word' is the data part
// of the frame as it will be after that edge. With SIPO_PARITY_EN the frame
// carries a trailing parity bit and 'parity_bad' reports odd overall parity.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic             shift,
  input  logic             si,
`ifdef SIPO_PARITY_EN
  output logic             parity_bad,
`endif
  output logic             done,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned FRAME = sipo_frame_len(WIDTH);
  localparam int unsigned SRW   = FRAME - 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  // Only FRAME-1 bits are ever stored: the last bit is consumed straight from
  // the combined value on the completing edge.
  logic [SRW-1:0]   sr;
  logic [FRAME-1:0] sr_next;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign sr_next = {sr, si};
  assign last    = (cnt == CNT_W'(FRAME - 1));
  assign done    = shift && last;
  assign word    = sr_next[FRAME-1 -: WIDTH];
`ifdef SIPO_PARITY_EN
  assign parity_bad = ^sr_next;
`endif

  // Start-of-frame reloads the register; strobes shift bits in at the LSB.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= SRW'(si);
      cnt <= CNT_W'(1);
    end else if (shift) begin
      sr  <= sr_next[SRW-1:0];
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a valid/ready output register.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                clrn,
  sipo_deserializer_if.slave  bus
);

  state_t           state_q, state_d;
  logic             load, shift, done, free;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r, overrun_r;

  // A start-of-frame strobe is accepted in any state, which gives restart in SHIFT.
  assign load  = bus.sen && bus.sof;
  assign shift = bus.sen && !bus.sof && (state_q == SHIFT);
  assign free  = !q_valid_r || bus.q_ready;

`ifdef SIPO_PARITY_EN
  logic parity_bad, perr_r;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .clrn       (clrn),
    .load       (load),
    .shift      (shift),
    .si         (bus.si),
    .parity_bad (parity_bad),
    .done       (done),
    .word       (word)
  );

  // Parity status travels with the word it belongs to.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perr_r <= 1'b0;
    end else if (done && free) begin
      perr_r <= parity_bad;
    end
  end

  assign bus.perr = perr_r;
`else
  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clrn  (clrn),
    .load  (load),
    .shift (shift),
    .si    (bus.si),
    .done  (done),
    .word  (word)
  );

  assign bus.perr = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter SHIFT on start-of-frame, return on frame completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (load) state_d = SHIFT;
      SHIFT: if (done) state_d = IDLE;
    endcase
  end

  // Output register: take a completed word when free, else drop and flag overrun.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= done && !free;
      if (done && free) begin
        q_r       <= word;
        q_valid_r <= 1'b1;
      end else if (q_valid_r && bus.q_ready) begin
        q_valid_r <= 1'b0;
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer at WIDTH=3, with or without SIPO_PARITY_EN.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  logic clk;
  logic clrn;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0] sb[$];   // {data, perr}

  sipo_deserializer_if #(.WIDTH(3)) bus();

  sipo_deserializer #(.WIDTH(3)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bus.si  = b;
    bus.sof = s;
    bus.sen = 1'b1;
    tick();
    bus.sen = 1'b0;
    bus.sof = 1'b0;
    bus.si  = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] d, input int unsigned stall,
                            input bit keep, input bit bad_par, input bit rdy_last);
    logic [3:0] bits;
    int unsigned n;
    logic pexp;
`ifdef SIPO_PARITY_EN
    bits = {d, (^d) ^ bad_par};
    n    = 4;
    pexp = bad_par;
`else
    bits = {d, bad_par};
    n    = 3;
    pexp = 1'b0;
`endif
    if (keep) sb.push_back({d, pexp});
    for (int i = 0; i < int'(n); i++) begin
      if (rdy_last && i == int'(n) - 1) bus.q_ready = 1'b1;
      send_bit(bits[3-i], i == 0);
      repeat (stall) tick();
    end
  endtask

  // Every consumed word must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (clrn && bus.q_valid && bus.q_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", {28'd0, bus.q, bus.perr}, 32'hFFFF_FFFF);
        end else begin
          check("word", {28'd0, bus.q, bus.perr}, {28'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.si = 1'b0; bus.sen = 1'b0; bus.sof = 1'b0; bus.q_ready = 1'b0;
    clrn = 1'b0;
    #12;
    check("rst_q", {29'd0, bus.q}, 32'd0);
    check("rst_q_valid", {31'd0, bus.q_valid}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_perr", {31'd0, bus.perr}, 32'd0);
    clrn = 1'b1;
    tick();

    // Strobes without start-of-frame in IDLE are ignored.
    bus.q_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("idle_ignore_valid", {31'd0, bus.q_valid}, 32'd0);

    // Basic frame: valid for exactly one cycle with ready high.
    send_frame(3'b101, 0, 1'b1, 1'b0, 1'b0);
    check("basic_valid", {31'd0, bus.q_valid}, 32'd1);
    check("basic_q", {29'd0, bus.q}, 32'd5);
    check("basic_overrun", {31'd0, bus.overrun}, 32'd0);
    tick();
    check("basic_valid_drop", {31'd0, bus.q_valid}, 32'd0);

    // Stalled frame.
    send_frame(3'b101, 2, 1'b1, 1'b0, 1'b0);
    tick();

    // Backpressure: second word dropped with a one-cycle overrun pulse.
    bus.q_ready = 1'b0;
    send_frame(3'b101, 0, 1'b1, 1'b0, 1'b0);
    send_frame(3'b011, 0, 1'b0, 1'b0, 1'b0);
    check("bp_overrun", {31'd0, bus.overrun}, 32'd1);
    check("bp_q_held", {29'd0, bus.q}, 32'd5);
    tick();
    check("bp_overrun_clear", {31'd0, bus.overrun}, 32'd0);
    check("bp_valid_held", {31'd0, bus.q_valid}, 32'd1);
    bus.q_ready = 1'b1;
    tick();
    check("bp_consumed", {31'd0, bus.q_valid}, 32'd0);

    // Simultaneous consume and complete.
    bus.q_ready = 1'b0;
    send_frame(3'b101, 0, 1'b1, 1'b0, 1'b0);
    send_frame(3'b110, 0, 1'b1, 1'b0, 1'b1);
    check("sim_valid", {31'd0, bus.q_valid}, 32'd1);
    check("sim_q", {29'd0, bus.q}, 32'd6);
    check("sim_overrun", {31'd0, bus.overrun}, 32'd0);
    tick();

    // Restart mid-frame discards the partial word.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_frame(3'b010, 0, 1'b1, 1'b0, 1'b0);
    check("restart_q", {29'd0, bus.q}, 32'd2);
    tick();

    // Reset mid-frame, then a clean frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    clrn = 1'b0;
    #2;
    check("mid_rst_q", {29'd0, bus.q}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.q_valid}, 32'd0);
    check("mid_rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("mid_rst_perr", {31'd0, bus.perr}, 32'd0);
    #3;
    clrn = 1'b1;
    tick();
    send_frame(3'b110, 0, 1'b1, 1'b0, 1'b0);
    tick();

    // Back-to-back frames.
    send_frame(3'b001, 0, 1'b1, 1'b0, 1'b0);
    send_frame(3'b100, 0, 1'b1, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    // Parity good and bad; q must not include the parity bit.
    send_frame(3'b101, 0, 1'b1, 1'b0, 1'b0);
    check("par_good_perr", {31'd0, bus.perr}, 32'd0);
    send_frame(3'b101, 0, 1'b1, 1'b1, 1'b0);
    check("par_bad_perr", {31'd0, bus.perr}, 32'd1);
    check("par_bad_q", {29'd0, bus.q}, 32'd5);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    check("sb_drain", sb.size(), 32'd0);
    check("end_valid", {31'd0, bus.q_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
